// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared glyphs and digit index type for the seven-segment display
package sevenseg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

    // Active-low glyphs, {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational 4-bit to active-low seven-segment decoder
module hex7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sum_sevenseg_display.sv
// rtl/sum_sevenseg_display.sv - multiplexed display of adder operands, carry and sum
module sum_sevenseg_display
    import sevenseg_pkg::*;
#(
    parameter int DIGIT_TICKS = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       cin,
    input  logic [3:0] out,
    input  logic       cout,
    input  logic       upd,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int              CW   = $clog2(DIGIT_TICKS);
    localparam logic [CW-1:0]   LAST = CW'(DIGIT_TICKS - 1);
    localparam digit_idx_t      IDX_IN1 = digit_idx_t'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic          wrap;
    digit_idx_t    idx;
    logic [3:0]    in1_h, in2_h, out_h;
    logic          cin_h, cout_h;
    logic [3:0]    nib;
    logic [6:0]    seg_d;

    assign wrap = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap)
                idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in1_h  <= '0;
            in2_h  <= '0;
            out_h  <= '0;
            cin_h  <= 1'b0;
            cout_h <= 1'b0;
        end else if (upd) begin
            in1_h  <= in1;
            in2_h  <= in2;
            out_h  <= out;
            cin_h  <= cin;
            cout_h <= cout;
        end
    end

    // Rightmost digit is the sum; leftmost is operand A
    always_comb begin
        nib = '0;
        case (idx)
            2'd0: nib = out_h;
            2'd1: nib = {3'b000, cout_h};
            2'd2: nib = in2_h;
            2'd3: nib = in1_h;
            default: nib = '0;
        endcase
    end

    hex7seg u_hex7seg (
        .nib (nib),
        .seg (seg_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= SEG_0;
            dp  <= 1'b1;
        end else begin
            an  <= blank ? 4'b1111 : ~(4'b0001 << idx);
            seg <= seg_d;
            dp  <= (idx == IDX_IN1) ? ~cin_h : 1'b1;
        end
    end

endmodule

// File: tb/tb_sum_sevenseg_display.sv
// tb/tb_sum_sevenseg_display.sv - directed self-checking bench for sum_sevenseg_display
module tb_sum_sevenseg_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in1, in2, out;
    logic       cin, cout, upd, blank;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GF = 7'b0001110;

    sum_sevenseg_display #(.DIGIT_TICKS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .in1   (in1),
        .in2   (in2),
        .cin   (cin),
        .out   (out),
        .cout  (cout),
        .upd   (upd),
        .blank (blank),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        chk({tag, "_an"},  {4'b0, an},  {4'b0, ea});
        chk({tag, "_seg"}, {1'b0, seg}, {1'b0, es});
        chk({tag, "_dp"},  {7'b0, dp},  {7'b0, ed});
    endtask

    // One full 16-cycle scan starting at the first lit cycle of digit 'start'
    task automatic scan(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                        input logic [6:0] e2, input logic [6:0] e3, input logic edp3,
                        input int start);
        logic [1:0] d;
        logic [6:0] es;
        for (int i = 0; i < 16; i++) begin
            tick();
            d = 2'((start + i / 4) % 4);
            case (d)
                2'd0: es = e0;
                2'd1: es = e1;
                2'd2: es = e2;
                default: es = e3;
            endcase
            chk_out(tag, ~(4'b0001 << d), es, (d == 2'd3) ? edp3 : 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1; in1 = '0; in2 = '0; out = '0; cin = 1'b0; cout = 1'b0;
        upd = 1'b0; blank = 1'b0;
        tick();
        tick();
        chk_out("reset", 4'b1110, G0, 1'b1);
        rst = 1'b0;

        // Scenario 1: reset in the middle of digit 1
        repeat (6) tick();
        chk_out("pre_rst_idx1", 4'b1101, G0, 1'b1);
        rst = 1'b1;
        #1;
        chk_out("async_rst", 4'b1110, G0, 1'b1);

        // Scenario 2: capture 3 + 5 + 1 = 9
        in1 = 4'h3; in2 = 4'h5; cin = 1'b1; out = 4'h9; cout = 1'b0; upd = 1'b1;
        rst = 1'b0;
        tick();
        upd = 1'b0;
        chk_out("first_after_rst", 4'b1110, G0, 1'b1);
        repeat (3) begin
            tick();
            chk_out("s2_idx0", 4'b1110, G9, 1'b1);
        end
        scan("s2", G9, G0, G5, G3, 1'b0, 1);

        // Scenario 3: input changes without upd stay invisible
        in1 = 4'h7; out = 4'h2;
        repeat (3) scan("s3", G9, G0, G5, G3, 1'b0, 1);

        // Scenario 4: all-F capture lands mid-digit 1
        in1 = 4'hF; in2 = 4'hF; cin = 1'b1; out = 4'hF; cout = 1'b1; upd = 1'b1;
        tick();
        upd = 1'b0;
        chk_out("s4_old", 4'b1101, G0, 1'b1);
        repeat (3) begin
            tick();
            chk_out("s4_idx1", 4'b1101, G1, 1'b1);
        end
        scan("s4", GF, G1, GF, GF, 1'b0, 2);

        // Scenario 5: blank during digit 1, scan keeps running
        repeat (12) tick();
        tick();
        chk_out("s5_pre", 4'b1101, G1, 1'b1);
        blank = 1'b1;
        tick();
        chk_out("s5_blank", 4'b1111, G1, 1'b1);
        repeat (5) begin
            tick();
            chk("s5_blank_hold", {4'b0, an}, 8'h0F);
        end
        blank = 1'b0;
        tick();
        chk_out("s5_unblank", 4'b1011, GF, 1'b1);

        // Scenario 6: capture on the same edge as the idx0->1 advance
        rst = 1'b1;
        #1;
        rst = 1'b0;
        in1 = 4'h3; in2 = 4'h5; cin = 1'b0; out = 4'h9; cout = 1'b1;
        repeat (3) tick();
        chk_out("s6_idx0", 4'b1110, G0, 1'b1);
        upd = 1'b1;
        tick();
        upd = 1'b0;
        chk_out("s6_wrap_edge", 4'b1110, G0, 1'b1);
        tick();
        chk_out("s6_new_digit", 4'b1101, G1, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
